// File: rtl/seq_pkg.sv
// Shared types and default pattern constants for the serial pattern generator and its detector.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } seq_state_t;

   localparam int         DEF_N   = 3;
   localparam logic [2:0] DEF_SEQ = 3'b101;
   localparam int         DEF_RW  = 8;

   // Bit-index width: $clog2(n), but never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_det.sv
// Serial pattern detector: pulses o_hit the cycle after the last N valid bits equal PATTERN.
module seq_det
   import seq_pkg::*;
#(
   parameter int         N       = DEF_N,
   parameter logic [N-1:0] PATTERN = DEF_SEQ
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_data,
   input  logic i_valid,
   output logic o_hit
);

   logic [N-1:0] r_shift;
   logic [N-1:0] r_mask;
   logic [N-1:0] w_shift;
   logic [N-1:0] w_mask;

   // r_mask tracks how many valid bits have been seen so a partly filled window never matches.
   assign w_shift = (r_shift << 1) | N'(i_data);
   assign w_mask  = (r_mask << 1) | N'(1'b1);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_shift <= '0;
         r_mask  <= '0;
         o_hit   <= 1'b0;
      end else begin
         o_hit <= 1'b0;
         if (i_valid) begin
            r_shift <= w_shift;
            r_mask  <= w_mask;
            o_hit   <= (&w_mask) && (w_shift == PATTERN);
         end
      end
   end

endmodule

// File: rtl/seq_gen.sv
// Burst serial pattern generator, MSB first, repeat count latched with start.
// Define SEQ_GEN_GAP_EN to insert one idle cycle between repetitions.
//
//   state | meaning
//   IDLE  | waiting for start
//   SEND  | driving pattern bit r_idx
//   GAP   | one idle cycle between repetitions (SEQ_GEN_GAP_EN only)
//   FIN   | done pulse cycle
module seq_gen
   import seq_pkg::*;
#(
   parameter int           N        = DEF_N,
   parameter logic [N-1:0] SEQUENCE = DEF_SEQ,
   parameter int           RW       = DEF_RW
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   input  logic          i_start,
   input  logic [RW-1:0] i_repeat_cnt,
   input  logic          i_abort,
   output logic          o_data_stream,
   output logic          o_valid,
   output logic          o_busy,
   output logic          o_done
);

   localparam int          IW       = idx_width(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   seq_state_t    r_state;
   logic [IW-1:0] r_idx;
   logic [RW-1:0] r_rep;
   logic [IW-1:0] w_idx_dec;

   assign w_idx_dec = r_idx - 1'b1;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_rep         <= '0;
         o_data_stream <= 1'b0;
         o_valid       <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else if (r_state != IDLE && i_abort) begin
         r_state       <= IDLE;
         o_data_stream <= 1'b0;
         o_valid       <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start && !i_abort) begin
                  o_busy <= 1'b1;
                  if (i_repeat_cnt != '0) begin
                     r_state       <= SEND;
                     r_rep         <= i_repeat_cnt;
                     r_idx         <= LAST_IDX;
                     o_data_stream <= SEQUENCE[N-1];
                     o_valid       <= 1'b1;
                  end else begin
                     r_state <= FIN;
                     r_rep   <= '0;
                  end
               end
            end
            SEND: begin
               if (r_idx != '0) begin
                  r_idx         <= w_idx_dec;
                  o_data_stream <= SEQUENCE[w_idx_dec];
               end else if (r_rep != RW'(1)) begin
                  r_rep <= r_rep - 1'b1;
`ifdef SEQ_GEN_GAP_EN
                  r_state       <= GAP;
                  o_data_stream <= 1'b0;
                  o_valid       <= 1'b0;
`else
                  r_idx         <= LAST_IDX;
                  o_data_stream <= SEQUENCE[N-1];
`endif
               end else begin
                  r_state       <= FIN;
                  r_rep         <= '0;
                  o_data_stream <= 1'b0;
                  o_valid       <= 1'b0;
                  o_done        <= 1'b1;
               end
            end
            GAP: begin
               r_state       <= SEND;
               r_idx         <= LAST_IDX;
               o_data_stream <= SEQUENCE[N-1];
               o_valid       <= 1'b1;
            end
            FIN: begin
               // A zero-length burst enters FIN with done low and raises it here.
               if (!o_done) begin
                  o_done <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  o_done  <= 1'b0;
                  o_busy  <= 1'b0;
               end
            end
            default: begin
               r_state       <= IDLE;
               o_data_stream <= 1'b0;
               o_valid       <= 1'b0;
               o_busy        <= 1'b0;
               o_done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen (default and n=8 instances) with seq_det on the default stream.
// Expectations follow SEQ_GEN_GAP_EN when the bench is built with it.
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort;
   logic [7:0] rc;
   logic       data, valid, busy, done, hit;

   logic       start8, abort8;
   logic [7:0] rc8;
   logic       data8, valid8, busy8, done8;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_gen u_dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_repeat_cnt(rc),
      .i_abort(abort), .o_data_stream(data), .o_valid(valid), .o_busy(busy), .o_done(done)
   );

   seq_det u_det (
      .i_clock(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid), .o_hit(hit)
   );

   seq_gen #(.N(8), .SEQUENCE(8'hA5), .RW(8)) u_dut8 (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start8), .i_repeat_cnt(rc8),
      .i_abort(abort8), .o_data_stream(data8), .o_valid(valid8), .o_busy(busy8), .o_done(done8)
   );

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; rc = 8'd0;
      start8 = 1'b0; abort8 = 1'b0; rc8 = 8'd0;
      #12;
      n_checks++;
      if ({busy, done, valid, data} !== 4'b0000) begin
         n_errors++; $display("FAIL reset: got %b expected 0000", {busy, done, valid, data});
      end
      n_checks++;
      if ({busy8, done8, valid8, data8, hit} !== 5'b00000) begin
         n_errors++; $display("FAIL reset8: got %b expected 00000", {busy8, done8, valid8, data8, hit});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [3:0] exp [5] = '{4'b1011, 4'b1010, 4'b1011, 4'b1100, 4'b0000};
      @(negedge clk); start = 1'b1; rc = 8'd1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({busy, done, valid, data} !== exp[i]) begin
            n_errors++;
            $display("FAIL single c%0d: got %b expected %b", i + 1, {busy, done, valid, data}, exp[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_detector();
      int         nvalid = 0, nhit = 0, ndone = 0;
      logic [11:0] stream = '0;
      start = 1'b1; rc = 8'd4;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (valid) begin nvalid++; stream = {stream[10:0], data}; end
         if (hit) nhit++;
         if (done) ndone++;
         @(negedge clk);
      end
      n_checks++;
      if (nvalid != 12) begin n_errors++; $display("FAIL det_valid: got %0d expected 12", nvalid); end
      n_checks++;
      if (stream !== 12'hB6D) begin n_errors++; $display("FAIL det_stream: got %b expected 101101101101", stream); end
      n_checks++;
      if (nhit != 4) begin n_errors++; $display("FAIL det_hits: got %0d expected 4", nhit); end
      n_checks++;
      if (ndone != 1) begin n_errors++; $display("FAIL det_done: got %0d expected 1", ndone); end
   endtask

   task automatic test_gap();
`ifdef SEQ_GEN_GAP_EN
      logic [3:0] exp [9] = '{4'b1011, 4'b1010, 4'b1011, 4'b1000, 4'b1011,
                              4'b1010, 4'b1011, 4'b1100, 4'b0000};
`else
      logic [3:0] exp [9] = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1010,
                              4'b1011, 4'b1100, 4'b0000, 4'b0000};
`endif
      start = 1'b1; rc = 8'd2;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         n_checks++;
         if ({busy, done, valid, data} !== exp[i]) begin
            n_errors++;
            $display("FAIL gap c%0d: got %b expected %b", i + 1, {busy, done, valid, data}, exp[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_zero_and_busy();
      logic [3:0] exp [3] = '{4'b1000, 4'b1100, 4'b0000};
      int nvalid = 0, ndone = 0;
      start = 1'b1; rc = 8'd0;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({busy, done, valid, data} !== exp[i]) begin
            n_errors++;
            $display("FAIL zero c%0d: got %b expected %b", i + 1, {busy, done, valid, data}, exp[i]);
         end
         @(negedge clk);
      end
      start = 1'b1; rc = 8'd1;
      @(negedge clk);
      for (int i = 1; i <= 8; i++) begin
         if (valid) nvalid++;
         if (done) ndone++;
         start = (i == 1 || i == 3 || i == 4);
         rc = 8'd2;
         @(negedge clk);
      end
      start = 1'b0;
      n_checks++;
      if (nvalid != 3) begin n_errors++; $display("FAIL busy_start_valid: got %0d expected 3", nvalid); end
      n_checks++;
      if (ndone != 1) begin n_errors++; $display("FAIL busy_start_done: got %0d expected 1", ndone); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
   endtask

   task automatic test_abort();
      int nbad = 0;
      @(negedge clk); start = 1'b1; rc = 8'd3;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, done, valid, data} !== 4'b1010) begin
         n_errors++; $display("FAIL abort_pre: got %b expected 1010", {busy, done, valid, data});
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      n_checks++;
      if ({busy, done, valid, data} !== 4'b0000) begin
         n_errors++; $display("FAIL abort_next: got %b expected 0000", {busy, done, valid, data});
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || valid || busy) nbad++;
      end
      n_checks++;
      if (nbad != 0) begin n_errors++; $display("FAIL abort_after: got %0d active cycles expected 0", nbad); end
   endtask

   task automatic test_reset_mid();
      int nbad = 0;
      start = 1'b1; rc = 8'd3;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre: got busy %b expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, valid, data} !== 4'b0000) begin
         n_errors++; $display("FAIL rstmid_async: got %b expected 0000", {busy, done, valid, data});
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy || valid || done) nbad++;
      end
      n_checks++;
      if (nbad != 0) begin n_errors++; $display("FAIL rstmid_resume: got %0d active cycles expected 0", nbad); end
   endtask

   task automatic test_long();
      int        nvalid = 0, ndone = 0, done_cyc = -1;
      logic [7:0] first = '0;
      @(negedge clk); start8 = 1'b1; rc8 = 8'd255;
      @(negedge clk); start8 = 1'b0;
      for (int i = 1; i <= 2045; i++) begin
         if (valid8) begin
            nvalid++;
            if (nvalid <= 8) first = {first[6:0], data8};
         end
         if (done8) begin ndone++; done_cyc = i; end
         @(negedge clk);
      end
      n_checks++;
      if (nvalid != 2040) begin n_errors++; $display("FAIL long_valid: got %0d expected 2040", nvalid); end
      n_checks++;
      if (first !== 8'hA5) begin n_errors++; $display("FAIL long_first: got %h expected a5", first); end
      n_checks++;
      if (ndone != 1) begin n_errors++; $display("FAIL long_done: got %0d expected 1", ndone); end
      n_checks++;
      if (done_cyc != 2041) begin n_errors++; $display("FAIL long_done_cyc: got %0d expected 2041", done_cyc); end
      n_checks++;
      if (busy8 !== 1'b0) begin n_errors++; $display("FAIL long_idle: got %b expected 0", busy8); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_detector();
      test_gap();
      test_zero_and_busy();
      test_abort();
      test_reset_mid();
      test_long();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
